// File: rtl/mat_vect_stream_master.sv
// rtl/mat_vect_stream_master.sv - host-side stream engine feeding a matrix-vector multiplier
module mat_vect_stream_master #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int RW = 2*DW + $clog2(N)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [$clog2(N*N)-1:0]   cfg_addr,
    input  logic [DW-1:0]            cfg_wdata,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err_tlast,
    output logic [DW-1:0]            out_vect,
    output logic                     out_vect_valid,
    input  logic                     out_vect_rdy,
    output logic [DW-1:0]            m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    input  logic [RW-1:0]            s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    input  logic [$clog2(N)-1:0]     res_addr,
    output logic [RW-1:0]            res_data
);
    localparam int AW = $clog2(N*N);
    localparam int VW = $clog2(N);
    localparam logic [AW-1:0] M_LAST = AW'(N*N-1);
    localparam logic [VW-1:0] V_LAST = VW'(N-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [DW-1:0] mat [N*N];
    logic [DW-1:0] vec [N];
    logic [RW-1:0] res [N];

    logic [VW-1:0] v_idx;
    logic [AW-1:0] m_idx;
    logic [VW-1:0] col;
    logic [VW-1:0] r_idx;
    // per-channel "all beats already exchanged" flags
    logic          v_fin;
    logic          m_fin;
    logic          r_fin;

    logic          v_hs;
    logic          m_hs;
    logic          r_hs;
    logic          v_all;
    logic          m_all;
    logic          r_all;
    logic [VW-1:0] col_next;

    assign v_hs  = out_vect_valid && out_vect_rdy;
    assign m_hs  = m_axis_tvalid && m_axis_tready;
    assign r_hs  = s_axis_tvalid && s_axis_tready;
    // a channel counts as complete if it finished earlier or finishes this cycle
    assign v_all = v_fin || (v_hs && v_idx == V_LAST);
    assign m_all = m_fin || (m_hs && m_idx == M_LAST);
    assign r_all = r_fin || (r_hs && r_idx == V_LAST);
    assign col_next = (col == V_LAST) ? '0 : col + 1'b1;

    // combinational result read; out-of-range indices read as zero
    always_comb begin
        res_data = '0;
        if (int'(res_addr) < N) begin
            res_data = res[res_addr];
        end
    end

    // control FSM, storage, and the three stream channels
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_tlast      <= 1'b0;
            out_vect       <= '0;
            out_vect_valid <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            s_axis_tready  <= 1'b0;
            v_idx          <= '0;
            m_idx          <= '0;
            col            <= '0;
            r_idx          <= '0;
            v_fin          <= 1'b0;
            m_fin          <= 1'b0;
            r_fin          <= 1'b0;
            for (int i = 0; i < N*N; i++) mat[i] <= '0;
            for (int i = 0; i < N; i++) vec[i] <= '0;
            for (int i = 0; i < N; i++) res[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        err_tlast      <= 1'b0;
                        v_idx          <= '0;
                        m_idx          <= '0;
                        col            <= '0;
                        r_idx          <= '0;
                        v_fin          <= 1'b0;
                        m_fin          <= 1'b0;
                        r_fin          <= 1'b0;
                        out_vect       <= vec[0];
                        out_vect_valid <= 1'b1;
                        m_axis_tdata   <= mat[0];
                        m_axis_tvalid  <= 1'b1;
                        m_axis_tlast   <= 1'b0;
                        s_axis_tready  <= 1'b1;
                        for (int i = 0; i < N; i++) res[i] <= '0;
                    end else if (cfg_we) begin
                        if (cfg_sel) begin
                            if (int'(cfg_addr[VW-1:0]) < N) vec[cfg_addr[VW-1:0]] <= cfg_wdata;
                        end else begin
                            if (int'(cfg_addr) < N*N) mat[cfg_addr] <= cfg_wdata;
                        end
                    end
                end
                RUN: begin
                    if (v_hs) begin
                        if (v_idx == V_LAST) begin
                            out_vect_valid <= 1'b0;
                            v_fin          <= 1'b1;
                        end else begin
                            v_idx    <= v_idx + 1'b1;
                            out_vect <= vec[v_idx + 1'b1];
                        end
                    end
                    if (m_hs) begin
                        if (m_idx == M_LAST) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_fin         <= 1'b1;
                        end else begin
                            m_idx        <= m_idx + 1'b1;
                            col          <= col_next;
                            m_axis_tdata <= mat[m_idx + 1'b1];
                            m_axis_tlast <= (col_next == V_LAST);
                        end
                    end
                    if (r_hs) begin
                        res[r_idx] <= s_axis_tdata;
                        if (s_axis_tlast != (r_idx == V_LAST)) err_tlast <= 1'b1;
                        if (r_idx == V_LAST) begin
                            s_axis_tready <= 1'b0;
                            r_fin         <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    if (v_all && m_all && r_all) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_vect_stream_master.sv
// tb/tb_mat_vect_stream_master.sv - directed self-checking bench for mat_vect_stream_master
module tb_mat_vect_stream_master;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int RW = 17;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cfg_we;
    logic          cfg_sel;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          start;
    logic          busy;
    logic          done;
    logic          err_tlast;
    logic [DW-1:0] out_vect;
    logic          out_vect_valid;
    logic          out_vect_rdy;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [RW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [0:0]    res_addr;
    logic [RW-1:0] res_data;

    always #5 aclk = ~aclk;

    mat_vect_stream_master #(.N(N), .DW(DW), .RW(RW)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .busy(busy), .done(done), .err_tlast(err_tlast),
        .out_vect(out_vect), .out_vect_valid(out_vect_valid), .out_vect_rdy(out_vect_rdy),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .res_addr(res_addr), .res_data(res_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] vq[$];
    logic [8:0] mq[$];
    int         done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input logic [7:0] d);
        @(negedge aclk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 2'(addr); cfg_wdata = d;
        @(negedge aclk);
        cfg_we = 1'b0;
    endtask

    task automatic load(input logic [7:0] m0, m1, m2, m3, v0, v1);
        wr(1'b0, 0, m0); wr(1'b0, 1, m1); wr(1'b0, 2, m2); wr(1'b0, 3, m3);
        wr(1'b1, 0, v0); wr(1'b1, 1, v1);
    endtask

    task automatic idle_inputs();
        start = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        out_vect_rdy = 1'b0; m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        res_addr = '0;
    endtask

    // one full transfer: consume both source channels, return results row by row
    task automatic run_xfer(input logic [RW-1:0] r0, r1, input logic tl0, tl1,
                            input bit bp, input bit poke);
        logic [RW-1:0] rv [2];
        logic          tl [2];
        int            rk;
        int            post;
        bit            seen_done;
        bit            pv_stall;
        bit            pm_stall;
        logic [7:0]    pv;
        logic [9:0]    pm;
        rv[0] = r0; rv[1] = r1; tl[0] = tl0; tl[1] = tl1;
        vq.delete(); mq.delete();
        done_cnt = 0; rk = 0; post = 0; seen_done = 0; pv_stall = 0; pm_stall = 0;
        pv = '0; pm = '0;
        @(negedge aclk); start = 1'b1;
        @(negedge aclk); start = 1'b0;
        for (int cyc = 0; cyc < 300 && post < 3; cyc++) begin
            if (cyc == 0) begin
                check("busy_in_run", busy, 1);
                check("err_clr_on_start", err_tlast, 0);
            end
            if (done) begin
                done_cnt++;
                seen_done = 1;
                check("done_after_results", rk, 2);
                check("done_after_vect", vq.size(), 2);
                check("done_after_mat", mq.size(), 4);
            end
            if (seen_done) post++;
            cfg_we = 1'b0;
            start  = 1'b0;
            if (poke && cyc == 1) begin
                start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 2'd3; cfg_wdata = 8'd99;
            end
            if (pv_stall) check("vect_hold", {out_vect_valid, out_vect}, {1'b1, pv});
            if (pm_stall) check("mat_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, pm);
            out_vect_rdy  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_vect_valid && out_vect_rdy) vq.push_back(out_vect);
            if (m_axis_tvalid && m_axis_tready) mq.push_back({m_axis_tlast, m_axis_tdata});
            pv_stall = out_vect_valid && !out_vect_rdy;
            pv       = out_vect;
            pm_stall = m_axis_tvalid && !m_axis_tready;
            pm       = {1'b1, m_axis_tlast, m_axis_tdata};
            if (rk < 2 && mq.size() >= (rk + 1) * N) begin
                s_axis_tvalid = 1'b1; s_axis_tdata = rv[rk]; s_axis_tlast = tl[rk];
            end else begin
                s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
            end
            if (s_axis_tvalid && s_axis_tready) rk++;
            @(negedge aclk);
        end
        if (!seen_done) check("xfer_timeout", 0, 1);
        idle_inputs();
        check("end_vect_valid", out_vect_valid, 0);
        check("end_mat_valid", m_axis_tvalid, 0);
        check("end_res_ready", s_axis_tready, 0);
        check("end_busy", busy, 0);
    endtask

    task automatic verify(input string tag, input logic [7:0] m0, m1, m2, m3, v0, v1,
                          input logic [RW-1:0] r0, r1, input logic e);
        logic [7:0] me [4];
        logic [7:0] ve [2];
        me[0] = m0; me[1] = m1; me[2] = m2; me[3] = m3; ve[0] = v0; ve[1] = v1;
        check($sformatf("%s_vect_count", tag), vq.size(), 2);
        check($sformatf("%s_mat_count", tag), mq.size(), 4);
        if (vq.size() == 2)
            for (int i = 0; i < 2; i++) check($sformatf("%s_vect%0d", tag, i), vq[i], ve[i]);
        if (mq.size() == 4)
            for (int i = 0; i < 4; i++)
                check($sformatf("%s_mat%0d", tag, i), mq[i], {(i % 2 == 1), me[i]});
        check($sformatf("%s_done_count", tag), done_cnt, 1);
        res_addr = 1'b0; #1;
        check($sformatf("%s_res0", tag), res_data, r0);
        res_addr = 1'b1; #1;
        check($sformatf("%s_res1", tag), res_data, r1);
        check($sformatf("%s_err_tlast", tag), err_tlast, e);
    endtask

    initial begin
        idle_inputs();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_tlast, 0);
        check("rst_vect_valid", out_vect_valid, 0);
        check("rst_mat_valid", m_axis_tvalid, 0);
        check("rst_res_ready", s_axis_tready, 0);
        check("rst_res_data", res_data, 0);
        areset = 1'b0;

        load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
        run_xfer(17'd17, 17'd39, 1'b0, 1'b1, 1'b0, 1'b0);
        verify("basic", 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 17'd17, 17'd39, 1'b0);

        void'($urandom(32'd7));
        run_xfer(17'd17, 17'd39, 1'b0, 1'b1, 1'b1, 1'b0);
        verify("bp", 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 17'd17, 17'd39, 1'b0);

        load(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        run_xfer(17'd130050, 17'd130050, 1'b0, 1'b1, 1'b0, 1'b0);
        verify("max", 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
               17'd130050, 17'd130050, 1'b0);

        load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
        run_xfer(17'd17, 17'd39, 1'b1, 1'b1, 1'b0, 1'b0);
        verify("frame", 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 17'd17, 17'd39, 1'b1);
        run_xfer(17'd17, 17'd39, 1'b0, 1'b1, 1'b0, 1'b0);
        verify("frame_clr", 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 17'd17, 17'd39, 1'b0);

        run_xfer(17'd17, 17'd39, 1'b0, 1'b1, 1'b0, 1'b1);
        verify("ctrl", 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 17'd17, 17'd39, 1'b0);

        @(negedge aclk); start = 1'b1;
        @(negedge aclk); start = 1'b0; m_axis_tready = 1'b1; out_vect_rdy = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("pre_reset_beat", m_axis_tdata, 3);
        areset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_mat_valid", m_axis_tvalid, 0);
        check("mid_rst_mat_data", m_axis_tdata, 0);
        check("mid_rst_mat_last", m_axis_tlast, 0);
        check("mid_rst_vect_valid", out_vect_valid, 0);
        check("mid_rst_vect", out_vect, 0);
        check("mid_rst_res_ready", s_axis_tready, 0);
        check("mid_rst_res_data", res_data, 0);
        idle_inputs();
        @(negedge aclk);
        areset = 1'b0;
        run_xfer(17'd0, 17'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        verify("cleared", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 17'd0, 17'd0, 1'b0);
        load(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
        run_xfer(17'd17, 17'd39, 1'b0, 1'b1, 1'b0, 1'b0);
        verify("after_rst", 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 17'd17, 17'd39, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mat_vect_stream_master.md
Name: mat_vect_stream_master

Overview:
- Drives a matrix-vector multiplier from the far end of its three interfaces.
- Holds an N x N matrix and an N-element vector, loaded through a simple config write port.
- On start:
  - streams the vector on a valid/ready element channel;
  - streams the matrix row-major on an AXI-Stream master with tlast per row;
  - collects the N dot-product results on an AXI-Stream slave into a readable result buffer.
- Used as the test/host-side engine for the multiplier datapath.

Parameters:
- N, 2, matrix dimension and vector length; N >= 2.
- DW, 8, element width, unsigned.
- RW, 2*DW+$clog2(N), result width.

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  0 = matrix, 1 = vector
- cfg_addr  in  $clog2(N*N)  matrix index row*N+col; vector uses low $clog2(N) bits
- cfg_wdata  in  DW  write data
- start  in  1  begin transfer (level sampled)
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err_tlast  out  1  sticky result-framing error
- out_vect  out  DW  vector element
- out_vect_valid  out  1  vector element valid
- out_vect_rdy  in  1  vector element accepted
- m_axis_tdata  out  DW  matrix element
- m_axis_tvalid  out  1  matrix beat valid
- m_axis_tlast  out  1  last element of a row
- m_axis_tready  in  1  matrix beat accepted
- s_axis_tdata  in  RW  result
- s_axis_tvalid  in  1  result valid
- s_axis_tlast  in  1  final result marker
- s_axis_tready  out  1  result accepted
- res_addr  in  $clog2(N)  result read index
- res_data  out  RW  result buffer read data (combinational read)

Behaviour:
- Reset: all outputs 0. Matrix, vector and result storage cleared. FSM = IDLE, all counters 0.
  - Reset mid-transfer aborts immediately to the same state; no done pulse.
- FSM states:
  - IDLE: busy=0. cfg_we writes storage. start high -> RUN.
  - RUN: busy=1. When all three channels are complete -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 -> IDLE.
- cfg_we is ignored in RUN and DONE, and in the IDLE cycle where start is accepted.
- start is ignored outside IDLE.
- On accepting start:
  - result buffer cleared; err_tlast cleared.
  - From the next cycle: out_vect_valid=1 with vec[0]; m_axis_tvalid=1 with mat[0][0]; s_axis_tready=1.
- Vector channel:
  - Element index j advances on out_vect_valid && out_vect_rdy.
  - After beat N-1 is accepted, out_vect_valid=0 for the rest of the transfer.
- Matrix channel:
  - Row r, column c advance row-major on each handshake; one beat per cycle when tready is held high.
  - m_axis_tlast=1 exactly when c==N-1.
  - After beat (N-1,N-1), tvalid=0.
- Stability rule (both source channels): data, last and valid are registered and held stable while valid && !ready; valid never drops without a handshake.
- The vector and matrix channels are independent. Either may stall while the other progresses; no ordering is imposed between them.
- Result channel:
  - On handshake k (k = 0..N-1), s_axis_tdata is stored to res[k].
  - s_axis_tready drops in the cycle after handshake N-1, and stays 0 outside RUN.
  - err_tlast is set if tlast=1 on k<N-1, or tlast=0 on k=N-1.
  - err_tlast stays set until the next accepted start; the transfer still completes.
- Completion: RUN -> DONE on the cycle where the last outstanding handshake occurs (vector N, matrix N*N, result N), regardless of which channel finishes last.
- res_data = res[res_addr] at all times. Out-of-range res_addr returns 0.
- No arithmetic is performed on results; they are stored unmodified at full RW width.

Test Plan:
- Basic: N=2, DW=8. Load mat=[[1,2],[3,4]], vec=[5,6]; start; bench returns 17, 39 with tlast on the second.
  - -> m_axis beats 1,2,3,4 with tlast on 2 and 4; out_vect 5,6; done pulse once; res[0]=17, res[1]=39; err_tlast=0.
- Backpressure: m_axis_tready and out_vect_rdy toggled pseudo-randomly (seed-fixed).
  - -> data/last/valid stable while stalled; beat order unchanged; done only after the last result.
- Max values: all elements 255; bench returns 130050 twice.
  - -> res_data=130050 with the full 17 bits intact.
- Framing error: bench returns the first result with tlast=1.
  - -> err_tlast=1, both results stored, done still pulses.
  - -> the next start clears err_tlast.
- Control: start pulsed during RUN -> ignored, single done. cfg_we during RUN -> storage unchanged.
- Reset mid-stream: assert areset after 2 matrix beats.
  - -> all outputs 0 and storage 0; a fresh load plus start completes normally.
